// File: rtl/bus_source_arbiter_if.sv
// Bundle of source request/data lines and the registered bus outputs of bus_source_arbiter.
// master = source side (register file / immediate path), slave = the arbiter.
interface bus_source_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NSRC  = 10
) ();
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_req;
  logic [NSRC-1:0]       grant;
  logic [WIDTH-1:0]      bus;
  logic                  bus_valid;
  logic [7:0]            collisions;

  modport master (
    output src_data, src_req,
    input  grant, bus, bus_valid, collisions
  );

  modport slave (
    input  src_data, src_req,
    output grant, bus, bus_valid, collisions
  );
endinterface

// File: rtl/bus_source_arbiter.sv
// Registered multi-source datapath bus arbiter with hold limit and collision counter.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin selection; default is fixed lowest-index priority.
//
//   state | meaning
//   IDLE  | no owner, bus driven to zero, bus_valid low
//   OWNED | source own_q owns the bus, hold_q counts consecutive contested cycles
module bus_source_arbiter #(
  parameter int WIDTH    = 16,
  parameter int NSRC     = 10,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  bus_source_arbiter_if.slave    bif
);

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     own_q, own_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [NSRC-1:0]   req;
  logic [NSRC-1:0]   own_mask;
  logic [NSRC-1:0]   others;
  logic [NSRC-1:0]   pick_mask;
  logic [IW-1:0]     win;
  logic              win_ok;
  logic              decide;
  logic              multi;

  logic [NSRC-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]  bus_q, bus_d;
  logic              valid_q, valid_d;
  logic [7:0]        coll_q, coll_d;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [IW-1:0]     rr_ptr_q;
`endif

  assign req = bif.src_req;

  always_comb begin
    own_mask        = '0;
    own_mask[own_q] = 1'b1;
  end

  // When the owner has released, others equals req, so one mask serves all decisions.
  assign others    = (state_q == OWNED) ? (req & ~own_mask) : req;
  assign pick_mask = others;
  assign multi     = |(req & (req - NSRC'(1)));

  // Winner search: descending loop so the first hit in scan order is the last assignment.
  always_comb begin
    win    = '0;
    win_ok = 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    for (int k = NSRC; k >= 1; k--) begin
      if (pick_mask[(int'(rr_ptr_q) + k) % NSRC]) begin
        win    = IW'((int'(rr_ptr_q) + k) % NSRC);
        win_ok = 1'b1;
      end
    end
`else
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pick_mask[i]) begin
        win    = IW'(i);
        win_ok = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      own_q    <= '0;
      hold_q   <= '0;
      grant_q  <= '0;
      bus_q    <= '0;
      valid_q  <= 1'b0;
      coll_q   <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      hold_q   <= hold_d;
      grant_q  <= grant_d;
      bus_q    <= bus_d;
      valid_q  <= valid_d;
      coll_q   <= coll_d;
    end
  end

`ifdef BUS_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= IW'(NSRC - 1);
    end else if (state_d == OWNED) begin
      rr_ptr_q <= own_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    hold_d  = hold_q;
    decide  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_ok) begin
          state_d = OWNED;
          own_d   = win;
          hold_d  = HW'(1);
          decide  = 1'b1;
        end
      end
      OWNED: begin
        if (!req[own_q]) begin
          decide = 1'b1;
          if (win_ok) begin
            own_d  = win;
            hold_d = HW'(1);
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else if (|others) begin
          if (hold_q == HW'(MAX_HOLD)) begin
            decide = 1'b1;
            own_d  = win;
            hold_d = HW'(1);
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end else begin
          // Uncontested ownership does not age toward a forced handover.
          hold_d = HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    grant_d = '0;
    bus_d   = '0;
    valid_d = 1'b0;
    coll_d  = coll_q;
    if (state_d == OWNED) begin
      grant_d[own_d] = 1'b1;
      bus_d          = bif.src_data[int'(own_d) * WIDTH +: WIDTH];
      valid_d        = 1'b1;
    end
    if (decide && multi && (coll_q != 8'hFF)) begin
      coll_d = coll_q + 8'd1;
    end
  end

  assign bif.grant      = grant_q;
  assign bif.bus        = bus_q;
  assign bif.bus_valid  = valid_q;
  assign bif.collisions = coll_q;

endmodule

// File: tb/tb_bus_source_arbiter.sv
// Self-checking bench for bus_source_arbiter: reference model feeding an expectation queue plus directed checks.
module tb_bus_source_arbiter;

  localparam int WIDTH    = 16;
  localparam int NSRC     = 10;
  localparam int MAX_HOLD = 8;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  bus_source_arbiter_if #(.WIDTH(WIDTH), .NSRC(NSRC)) bif ();

  bus_source_arbiter #(
    .WIDTH(WIDTH),
    .NSRC(NSRC),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bif(bif)
  );

  typedef struct {
    logic [NSRC-1:0]  g;
    logic [WIDTH-1:0] b;
    logic             v;
    logic [7:0]       c;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;

  bit m_owned;
  int m_own;
  int m_hold;
  int m_ptr;
  int m_coll;

  int hold_cnt;
  int cur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NSRC-1:0] m, input int p);
    int r;
    r = -1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    for (int k = NSRC; k >= 1; k--)
      if (m[(p + k) % NSRC]) r = (p + k) % NSRC;
`else
    for (int i = NSRC - 1; i >= 0; i--)
      if (m[i]) r = i;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_owned = 1'b0;
    m_own   = 0;
    m_hold  = 0;
    m_ptr   = NSRC - 1;
    m_coll  = 0;
    q.delete();
  endtask

  // Predict the state after the coming edge from the inputs currently driven.
  task automatic model_step();
    logic [NSRC-1:0] r, oth, one;
    int nxt;
    bit dec;
    exp_t e;
    r   = bif.src_req;
    nxt = -1;
    dec = 1'b0;
    if (!m_owned) begin
      if (r != 0) begin dec = 1'b1; nxt = pick(r, m_ptr); m_hold = 1; end
    end else if (!r[m_own]) begin
      dec = 1'b1;
      if (r != 0) begin nxt = pick(r, m_ptr); m_hold = 1; end
      else m_hold = 0;
    end else begin
      one = '0; one[m_own] = 1'b1;
      oth = r & ~one;
      if (oth != 0 && m_hold == MAX_HOLD) begin
        dec = 1'b1; nxt = pick(oth, m_ptr); m_hold = 1;
      end else begin
        nxt = m_own;
        if (oth != 0) m_hold = (m_hold < MAX_HOLD) ? m_hold + 1 : MAX_HOLD;
        else m_hold = 1;
      end
    end
    if (dec && $countones(r) >= 2 && m_coll < 255) m_coll++;
    m_owned = (nxt >= 0);
    e.g = '0; e.b = '0; e.v = 1'b0;
    if (m_owned) begin
      m_own = nxt;
      m_ptr = nxt;
      e.g[nxt] = 1'b1;
      e.b = bif.src_data[nxt*WIDTH +: WIDTH];
      e.v = 1'b1;
    end
    e.c = 8'(m_coll);
    q.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    model_step();
    @(posedge clock);
    #1;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_grant"}, 32'(bif.grant), 32'(e.g));
      chk({tag, "_bus"}, 32'(bif.bus), 32'(e.b));
      chk({tag, "_valid"}, 32'(bif.bus_valid), 32'(e.v));
      chk({tag, "_coll"}, 32'(bif.collisions), 32'(e.c));
      chk({tag, "_valid_eq_or_grant"}, 32'(bif.bus_valid), 32'(|bif.grant));
    end
  endtask

  task automatic set_data(input int idx, input logic [WIDTH-1:0] d);
    bif.src_data[idx*WIDTH +: WIDTH] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bif.src_req  = '0;
    bif.src_data = '0;
    model_reset();
    #12;
    chk("reset_grant", 32'(bif.grant), 32'h0);
    chk("reset_bus", 32'(bif.bus), 32'h0);
    chk("reset_valid", 32'(bif.bus_valid), 32'h0);
    chk("reset_coll", 32'(bif.collisions), 32'h0);
    reset = 1'b0;

    // Single request
    set_data(2, 16'h1234);
    bif.src_req = 10'h004;
    step("single");
    chk("single_grant_c", 32'(bif.grant), 32'h004);
    chk("single_bus_c", 32'(bif.bus), 32'h1234);
    chk("single_valid_c", 32'(bif.bus_valid), 32'h1);
    chk("single_coll_c", 32'(bif.collisions), 32'h0);
    bif.src_req = '0;
    step("idle1");

    // Collision from IDLE, then back-to-back handover
    set_data(1, 16'h1111);
    bif.src_req = 10'h006;
    step("coll");
    chk("coll_grant_c", 32'(bif.grant), 32'h002);
    chk("coll_count_c", 32'(bif.collisions), 32'h1);
    bif.src_req = 10'h004;
    step("handover");
    chk("handover_grant_c", 32'(bif.grant), 32'h004);
    bif.src_req = '0;
    step("idle2");

    // Hold limit: source 0 keeps requesting while source 3 waits
    set_data(0, 16'h0A0A);
    set_data(3, 16'h3333);
    bif.src_req = 10'h009;
    step("hold_start");
    hold_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bif.grant != 10'h001) break;
      hold_cnt++;
      step("hold");
    end
    chk("hold_cycles", 32'(hold_cnt), 32'd8);
    chk("hold_forced_grant", 32'(bif.grant), 32'h008);
    bif.src_req = '0;
    step("idle3");

    // Asynchronous reset mid-ownership
    set_data(0, 16'hBEEF);
    bif.src_req = 10'h001;
    step("pre_reset");
    chk("pre_reset_bus_c", 32'(bif.bus), 32'hBEEF);
    reset = 1'b1;
    #1;
    chk("async_rst_bus", 32'(bif.bus), 32'h0);
    chk("async_rst_grant", 32'(bif.grant), 32'h0);
    chk("async_rst_valid", 32'(bif.bus_valid), 32'h0);
    chk("async_rst_coll", 32'(bif.collisions), 32'h0);
    model_reset();
    bif.src_req = '0;
    reset = 1'b0;

    // Ordering with every source requesting and each owner dropping for a cycle
    for (int i = 0; i < NSRC; i++) set_data(i, 16'(16'hA000 + i));
    bif.src_req = 10'h3FF;
    step("order_first");
    chk("order_first_c", 32'(bif.grant), 32'h001);
    for (int i = 0; i < NSRC; i++) begin
      bif.src_req = 10'h3FF & ~bif.grant;
      step("order");
`ifdef BUS_ARB_ROUND_ROBIN_EN
      cur = (i + 1) % NSRC;
`else
      cur = (i % 2 == 0) ? 1 : 0;
`endif
      chk("order_c", 32'(bif.grant), 32'(1 << cur));
    end
    bif.src_req = '0;
    step("idle4");

    // Random traffic against the model
    for (int i = 0; i < 80; i++) begin
      bif.src_req = 10'($urandom_range(0, 1023) & $urandom_range(0, 1023));
      for (int s = 0; s < NSRC; s++) set_data(s, 16'($urandom));
      step("rand");
    end
    bif.src_req = '0;
    step("idle5");

    // Collision counter saturation
    for (int i = 0; i < 300; i++) begin
      bif.src_req = 10'h003;
      step("sat_on");
      bif.src_req = '0;
      step("sat_off");
    end
    chk("sat_coll_c", 32'(bif.collisions), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
